// File: rtl/bp_nonsynth_cosim_sched.sv
`default_nettype none
// ============================================================================
// Module  : bp_nonsynth_cosim_sched
// Brief   : Round-robin sharing of the single cosim step port among cores, with
//           run sequencing (init, budget, drain, watchdog) and finish reporting.
// Rev     : 1.0
// ============================================================================
module bp_nonsynth_cosim_sched #(
    parameter int num_core_p  = 2,
    parameter int rec_width_p = 138,
    parameter int cnt_width_p = 32,
    parameter int timeout_p   = 65536,
    localparam int ID_W = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic                              en_i,
    input  logic                              init_done_i,
    input  logic [cnt_width_p-1:0]            cosim_instr_i,
    input  logic [num_core_p-1:0]             rec_v_i,
    input  logic [num_core_p*rec_width_p-1:0] rec_i,
    input  logic [num_core_p-1:0]             rec_commit_i,
    output logic [num_core_p-1:0]             rec_ready_o,
    output logic                              v_o,
    output logic [rec_width_p-1:0]            data_o,
    output logic [ID_W-1:0]                   core_id_o,
    input  logic                              yumi_i,
    output logic [num_core_p-1:0]             finish_o,
    output logic                              all_finish_o,
    output logic                              timeout_o
);
    localparam int OFF_W = ID_W + 1;
    localparam int WD_W  = $clog2(timeout_p + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INIT  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    state_e                                  state_q, state_d;
    logic                                    v_q, v_d;
    logic [rec_width_p-1:0]                  data_q, data_d;
    logic [ID_W-1:0]                         id_q, id_d;
    logic [ID_W-1:0]                         ptr_q, ptr_d;
    logic [num_core_p-1:0][cnt_width_p-1:0]  cnt_q, cnt_d;
    logic [num_core_p-1:0]                   fin_q, fin_d;
    logic                                    to_q, to_d;
    logic                                    af_q, af_d;
    logic [WD_W-1:0]                         wd_q, wd_d;

    logic [num_core_p-1:0][rec_width_p-1:0]  recs;
    logic [num_core_p-1:0]                   elig, elig_rot, ready;
    logic [OFF_W-1:0]                        off, sum;
    logic [ID_W-1:0]                         gnt;
    logic                                    gnt_v, out_free, fwd, stall;

    assign recs = rec_i;

    // Rotate eligibility so bit 0 is the highest-priority core, then pick the lowest set bit.
    always_comb begin
        elig     = rec_v_i & ~fin_q;
        elig_rot = num_core_p'({elig, elig} >> ptr_q);
        gnt_v    = 1'b0;
        off      = '0;
        for (int j = num_core_p - 1; j >= 0; j--) begin
            if (elig_rot[j]) begin
                gnt_v = 1'b1;
                off   = OFF_W'(j);
            end
        end
        sum = {1'b0, ptr_q} + off;
        gnt = (sum >= OFF_W'(num_core_p)) ? ID_W'(sum - OFF_W'(num_core_p)) : ID_W'(sum);
    end

    always_comb begin
        state_d  = state_q;
        v_d      = v_q;
        data_d   = data_q;
        id_d     = id_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        fin_d    = fin_q;
        to_d     = to_q;
        af_d     = af_q;
        wd_d     = '0;
        ready    = '0;
        fwd      = 1'b0;
        out_free = ~v_q | yumi_i;

        case (state_q)
            S_IDLE: begin
                if (!en_i) ready = '1;
                else       state_d = S_INIT;
            end
            S_INIT: begin
                if (init_done_i) state_d = S_RUN;
            end
            S_RUN, S_DRAIN: begin
                // Finished cores are always accepted so their records are sunk.
                ready = fin_q;
                if (gnt_v && out_free) begin
                    ready[gnt] = 1'b1;
                    fwd        = 1'b1;
                end
            end
            default: ;
        endcase

        if (v_q && yumi_i) v_d = 1'b0;
        if (fwd) begin
            v_d    = 1'b1;
            data_d = recs[gnt];
            id_d   = gnt;
            ptr_d  = (gnt == ID_W'(num_core_p - 1)) ? '0 : gnt + 1'b1;
            if (rec_commit_i[gnt] && (cnt_q[gnt] != '1)) cnt_d[gnt] = cnt_q[gnt] + 1'b1;
        end

        for (int i = 0; i < num_core_p; i++) begin
            if ((cosim_instr_i != '0) && (cnt_d[i] >= cosim_instr_i)) fin_d[i] = 1'b1;
        end

        stall = ((|rec_v_i) | v_q) & ~(|(rec_v_i & ready)) & ~(v_q & yumi_i);

        if (state_q == S_RUN && (&fin_q)) state_d = S_DRAIN;
        if (state_q == S_DRAIN && !v_q) begin
            state_d = S_DONE;
            af_d    = 1'b1;
        end

        if ((state_q == S_RUN || state_q == S_DRAIN) && stall) begin
            if (wd_q == WD_W'(timeout_p - 1)) begin
                to_d    = 1'b1;
                af_d    = af_q;
                v_d     = 1'b0;
                state_d = S_DONE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= S_IDLE;
            v_q     <= 1'b0;
            data_q  <= '0;
            id_q    <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
            fin_q   <= '0;
            to_q    <= 1'b0;
            af_q    <= 1'b0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            v_q     <= v_d;
            data_q  <= data_d;
            id_q    <= id_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            fin_q   <= fin_d;
            to_q    <= to_d;
            af_q    <= af_d;
            wd_q    <= wd_d;
        end
    end

    assign rec_ready_o  = reset_i ? ready : '0;
    assign v_o          = v_q;
    assign data_o       = data_q;
    assign core_id_o    = id_q;
    assign finish_o     = fin_q;
    assign all_finish_o = af_q;
    assign timeout_o    = to_q;

endmodule
`default_nettype wire
